// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Package name ps2_pkg is shared with the receive side of the keyboard I/O block.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_XFER,
        ST_WAIT_IDLE,
        ST_DONE
    } ps2_tx_state_e;

    localparam int PS2_FRAME_FALLS = 11;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the system side and the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_error,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_error,
        output busy
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines plus a registered
// falling-edge strobe on the clock; also used by the receive path.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o
);

    logic clk_meta_q;
    logic clk_sync_q;
    logic clk_prev_q;
    logic data_meta_q;
    logic data_sync_q;
    logic fall_q;

    // Reset to the idle (pulled-up) line level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
            fall_q      <= clk_prev_q & ~clk_sync_q;
        end
    end

    assign clk_sync_o  = clk_sync_q;
    assign data_sync_o = data_sync_q;
    assign clk_fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Optional watchdog on XFER/WAIT_IDLE is enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int CNT_SPAN = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_SPAN + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [3:0]       LAST_FALL_IDX = 4'(PS2_FRAME_FALLS - 1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
`endif

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             data_oe_q, data_oe_d;

    logic clk_sync;
    logic data_sync;
    logic clk_fall;
    logic accept;
    logic frame_end;
    logic nack;
    logic timeout;

    ps2_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (ps2_clk_in),
        .ps2_data_i  (ps2_data_in),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .clk_fall_o  (clk_fall)
    );

    assign accept    = (state_q == ST_IDLE) & tx.tx_valid;
    assign frame_end = (state_q == ST_XFER) & clk_fall & (bit_cnt_q == LAST_FALL_IDX);
    assign nack      = frame_end & data_sync;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    assign timeout = ((state_q == ST_XFER) || (state_q == ST_WAIT_IDLE)) && (cnt_q >= TIMEOUT_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            data_oe_q <= data_oe_d;
        end
    end

    // Data enable is only updated on a synchronized falling edge or on state entry/exit,
    // so the device never sees the data line move while its clock is high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        data_oe_d = data_oe_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                data_oe_d = 1'b0;
                if (accept) begin
                    data_d  = tx.tx_data;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REQ: begin
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~ps2_odd_parity(data_q);
                    end else if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                    end else begin
                        state_d = data_sync ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
        if ((state_q == ST_XFER) || (state_q == ST_WAIT_IDLE)) begin
            if (timeout) begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                data_oe_d = 1'b0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // Error is flagged in the last XFER/WAIT_IDLE cycle so ready rises only after the pulse.
    always_comb begin
        tx.tx_ready = (state_q == ST_IDLE);
        tx.busy     = (state_q != ST_IDLE);
        tx.tx_done  = (state_q == ST_DONE);
        tx.tx_error = nack | timeout;
        ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
        ps2_data_oe = data_oe_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Timeout behaviour is checked according to whether PS2_HOST_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 10;
    localparam int BOUND   = 5000;

    logic clock;
    logic reset;
    logic ps2ClkOe;
    logic ps2DataOe;
    logic devClkLow;
    logic devDataLow;
    logic ps2ClkLine;
    logic ps2DataLine;

    int checkCount   = 0;
    int passCount    = 0;
    int doneSeen     = 0;
    int errSeen      = 0;
    int oeViolations = 0;
    bit inFrame      = 0;
    logic lastDataOe = 1'b0;

    ps2_host_tx_if txIf ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clock),
        .reset       (reset),
        .tx          (txIf),
        .ps2_clk_in  (ps2ClkLine),
        .ps2_data_in (ps2DataLine),
        .ps2_clk_oe  (ps2ClkOe),
        .ps2_data_oe (ps2DataOe)
    );

    // Open-drain bus: either side pulling low wins, otherwise the pull-up holds it high.
    assign ps2ClkLine  = ~(ps2ClkOe | devClkLow);
    assign ps2DataLine = ~(ps2DataOe | devDataLow);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count pulses and watch for the host moving data while the PS/2 clock is high.
    always @(negedge clock) begin
        if (txIf.tx_done === 1'b1) doneSeen++;
        if (txIf.tx_error === 1'b1) errSeen++;
        if (inFrame && (ps2DataOe !== lastDataOe) && (ps2ClkLine === 1'b1)) oeViolations++;
        lastDataOe = ps2DataOe;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Expected 11-bit frame as seen on the wire: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] refFrame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        txIf.tx_valid = 1'b1;
        txIf.tx_data  = b;
        tick();
        txIf.tx_valid = 1'b0;
        txIf.tx_data  = 8'h00;
    endtask

    task automatic measureRequest(output int inhibitLen, output int reqLen);
        inhibitLen = 0;
        reqLen     = 0;
        while ((ps2ClkOe === 1'b1) && (ps2DataOe === 1'b0) && (inhibitLen < BOUND)) begin
            inhibitLen++;
            tick();
        end
        while ((ps2ClkOe === 1'b1) && (ps2DataOe === 1'b1) && (reqLen < BOUND)) begin
            reqLen++;
            tick();
        end
    endtask

    task automatic deviceClock(input int falls, input bit nack, output logic [10:0] rx);
        int w;
        w  = 0;
        rx = '0;
        while (!((ps2ClkLine === 1'b1) && (ps2DataLine === 1'b0)) && (w < BOUND)) begin
            tick();
            w++;
        end
        checkOutput("requestSeen", (w < BOUND), 1);
        rx[0] = ps2DataLine;
        repeat (HALF) tick();
        inFrame = 1;
        for (int n = 1; n <= falls && n <= 10; n++) begin
            devClkLow = 1'b1;
            repeat (HALF) tick();
            devClkLow = 1'b0;
            rx[n] = ps2DataLine;
            repeat (HALF) tick();
        end
        if (falls >= 11) begin
            devDataLow = !nack;
            repeat (HALF) tick();
            devClkLow = 1'b1;
            repeat (HALF) tick();
            devClkLow = 1'b0;
            repeat (HALF) tick();
            devDataLow = 1'b0;
        end
        inFrame = 0;
    endtask

    task automatic waitReady(input string name);
        int w;
        w = 0;
        while ((txIf.tx_ready !== 1'b1) && (w < BOUND)) begin
            tick();
            w++;
        end
        checkOutput({name, ".readyReturn"}, (w < BOUND), 1);
        repeat (3) tick();
    endtask

    task automatic runFrame(input logic [7:0] b, input bit nack, input bit injectValid, input string name);
        int inh, req, doneBase, errBase;
        logic [10:0] rx;
        doneBase = doneSeen;
        errBase  = errSeen;
        applyStimulus(b);
        measureRequest(inh, req);
        checkOutput({name, ".inhibitLen"}, inh, INHIBIT);
        checkOutput({name, ".reqLen"}, req, 1);
        if (injectValid) begin
            fork
                deviceClock(11, nack, rx);
                begin
                    repeat (5 * HALF) tick();
                    checkOutput({name, ".readyInXfer"}, txIf.tx_ready, 0);
                    txIf.tx_valid = 1'b1;
                    txIf.tx_data  = 8'h00;
                    tick();
                    txIf.tx_valid = 1'b0;
                end
            join
        end else begin
            deviceClock(11, nack, rx);
        end
        waitReady(name);
        checkOutput({name, ".bits"}, rx, refFrame(b));
        checkOutput({name, ".doneCount"}, doneSeen - doneBase, nack ? 0 : 1);
        checkOutput({name, ".errorCount"}, errSeen - errBase, nack ? 1 : 0);
        checkOutput({name, ".linesReleased"}, {ps2ClkOe, ps2DataOe}, 2'b00);
        checkOutput({name, ".busyIdle"}, txIf.busy, 0);
    endtask

    initial begin
        int inh, req, doneBase, errBase, k;
        logic [10:0] rx;
        logic [7:0] b;
        bit nack;

        reset         = 1'b1;
        txIf.tx_valid = 1'b0;
        txIf.tx_data  = 8'h00;
        devClkLow     = 1'b0;
        devDataLow    = 1'b0;
        repeat (3) tick();
        checkOutput("reset.ready", txIf.tx_ready, 1);
        checkOutput("reset.busy", txIf.busy, 0);
        checkOutput("reset.done", txIf.tx_done, 0);
        checkOutput("reset.error", txIf.tx_error, 0);
        checkOutput("reset.lines", {ps2ClkOe, ps2DataOe}, 2'b00);
        reset = 1'b0;
        tick();

        runFrame(PS2_CMD_SET_LEDS, 1'b0, 1'b0, "setLeds");
        runFrame(PS2_CMD_ENABLE, 1'b0, 1'b0, "enable");
        runFrame(8'hA5, 1'b1, 1'b0, "nack");
        checkOutput("nack.ready", txIf.tx_ready, 1);

        for (int i = 0; i < 5; i++) begin
            b    = 8'($urandom_range(0, 255));
            nack = ($urandom_range(0, 3) == 0);
            runFrame(b, nack, 1'b0, "random");
        end

        runFrame(PS2_CMD_SET_LEDS, 1'b0, 1'b1, "ignoreValid");

        // Abort after the fifth falling edge; bit 4 of 0xED is 0 so data is being pulled low.
        doneBase = doneSeen;
        errBase  = errSeen;
        applyStimulus(PS2_CMD_SET_LEDS);
        measureRequest(inh, req);
        deviceClock(5, 1'b0, rx);
        checkOutput("abort.dataPulled", ps2DataOe, 1);
        reset = 1'b1;
        tick();
        checkOutput("abort.clkOe", ps2ClkOe, 0);
        checkOutput("abort.dataOe", ps2DataOe, 0);
        checkOutput("abort.ready", txIf.tx_ready, 1);
        reset = 1'b0;
        repeat (2) tick();
        checkOutput("abort.noDone", doneSeen - doneBase, 0);
        checkOutput("abort.noError", errSeen - errBase, 0);
        runFrame(PS2_CMD_RESET, 1'b0, 1'b0, "afterAbort");

        doneBase = doneSeen;
        errBase  = errSeen;
        applyStimulus(PS2_CMD_ENABLE);
        measureRequest(inh, req);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        k = 0;
        while ((txIf.tx_error !== 1'b1) && (k < TIMEOUT + 100)) begin
            tick();
            k++;
        end
        checkOutput("timeout.latency", k, TIMEOUT);
        tick();
        checkOutput("timeout.lines", {ps2ClkOe, ps2DataOe}, 2'b00);
        checkOutput("timeout.ready", txIf.tx_ready, 1);
        tick();
        checkOutput("timeout.errorCount", errSeen - errBase, 1);
        checkOutput("timeout.noDone", doneSeen - doneBase, 0);
`else
        k = 0;
        repeat (TIMEOUT + 100) tick();
        checkOutput("noTimeout.busyHeld", txIf.busy, 1);
        checkOutput("noTimeout.noError", errSeen - errBase, k);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("noTimeout.readyAfterReset", txIf.tx_ready, 1);
`endif

        checkOutput("dataOeStable", oeViolations, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the system to the keyboard. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables. Sits alongside the PS/2 receive path in the keyboard I/O block; `busy` tells the receiver to ignore line activity while a command is in flight.

## Interface
- `INHIBIT_CYCLES`, 5000: system clocks the PS/2 clock is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: watchdog limit from clock release to completion (15 ms at 50 MHz).
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `tx_data` in 8: command byte.
- `tx_valid` in 1: request; accepted when `tx_valid & tx_ready`.
- `tx_ready` out 1: high only in IDLE.
- `tx_done` out 1: one-cycle pulse on acknowledged completion.
- `tx_error` out 1: one-cycle pulse on NACK or timeout.
- `busy` out 1: high in every state except IDLE.
- `ps2_clk_in` in 1: raw PS/2 clock line (asynchronous).
- `ps2_data_in` in 1: raw PS/2 data line (asynchronous).
- `ps2_clk_oe` out 1: 1 pulls the PS/2 clock low.
- `ps2_data_oe` out 1: 1 pulls the PS/2 data low.

## Operation
- Inputs pass through a 2-FF synchronizer. A falling edge (`fall`) is `prev & ~sync` on the synchronized clock.
- On accept: latch `tx_data` into the shift register. Parity = `~^tx_data` (odd).
- States and transitions:
  - IDLE: all outputs released. On accept → INHIBIT.
  - INHIBIT: `clk_oe=1` for exactly INHIBIT_CYCLES clocks → REQ.
  - REQ: `clk_oe=1`, `data_oe=1` for one clock → XFER. This is the start bit.
  - XFER: `clk_oe=0`; bit counter 0..10, advanced on `fall` only:
    - fall 1..8: `data_oe = ~data[n-1]`, LSB first.
    - fall 9: `data_oe = ~parity`.
    - fall 10: `data_oe=0` (stop bit, line released).
    - fall 11: sample `ps2_data_in` sync. 0 → WAIT_IDLE; 1 → NACK, `tx_error` pulse, IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1 → DONE.
  - DONE: `tx_done` pulse for one cycle → IDLE.
- `tx_valid` while not IDLE is ignored; no queueing.
- `ps2_data_oe` changes only on `fall` or on state entry/exit. It never changes while the PS/2 clock is high mid-transfer.

## Timing
- Reset values: state IDLE, `tx_ready=1`, `busy=0`, `tx_done=0`, `tx_error=0`, `ps2_clk_oe=0`, `ps2_data_oe=0`, counters 0.
- Reset mid-operation: lines released on the next clock, with no done/error pulse.
- Accept at cycle 0 → `ps2_clk_oe` high from cycle 1 through cycle INHIBIT_CYCLES.
- REQ occupies cycle INHIBIT_CYCLES+1. `clk_oe` falls at cycle INHIBIT_CYCLES+2.
- A device edge reaches `fall` 3 system clocks after the raw line edge (2 sync + 1 edge detect). `data_oe` updates on the following clock.
- `tx_done` is asserted one cycle after both lines are seen idle.
- Done/error pulses are mutually exclusive. `tx_ready` returns the cycle after either pulse.
- Counter width: `$clog2(max(INHIBIT_CYCLES,TIMEOUT_CYCLES)+1)`. The counter saturates and never wraps.

## Configuration
- Macro: `PS2_HOST_TX_TIMEOUT_EN`.
- Defined: the watchdog counts from XFER entry. Reaching TIMEOUT_CYCLES in XFER or WAIT_IDLE releases both lines, pulses `tx_error`, and returns to IDLE. This covers a missing or unplugged device.
- Undefined: no watchdog. XFER and WAIT_IDLE wait indefinitely, and only NACK produces `tx_error`.

## Structure
- `ps2_pkg`:
  - state enum (IDLE, INHIBIT, REQ, XFER, WAIT_IDLE, DONE);
  - `PS2_FRAME_FALLS = 11`;
  - command constants `PS2_CMD_SET_LEDS=8'hED`, `PS2_CMD_ENABLE=8'hF4`, `PS2_CMD_RESET=8'hFF`.
- Sub-module `ps2_line_sync`: 2-FF synchronizer for clock and data plus falling-edge detect. It is shared with the receive path.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → start 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Then `tx_done` pulses once and `tx_error` stays 0.
- Send 0xF4 → parity bit 0. Measure `ps2_clk_oe` high for exactly INHIBIT_CYCLES clocks, then REQ lasts 1 clock with `data_oe=1`.
- Device holds data high at fall 11 → one `tx_error` pulse, no `tx_done`, lines released, `tx_ready=1`.
- With `PS2_HOST_TX_TIMEOUT_EN`, device never clocks → `tx_error` at TIMEOUT_CYCLES after clock release. Without the macro, `busy` stays 1.
- Assert `reset` after fall 5 → next cycle `ps2_clk_oe=0`, `ps2_data_oe=0`, `tx_ready=1`, no pulses. A new 0xFF then completes normally.
- Pulse `tx_valid` with 0x00 during XFER of 0xED → ignored, and the transmitted byte remains 0xED.
